// File: rtl/ttl_latch_strobe_arbiter.sv
// Two-requester round-robin writer for a bank of eight 6-bit latches.
// Each write drives Lat_D, pulses a single Lat_Cen bit, then holds off before acknowledging.
module ttl_latch_strobe_arbiter #(
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned GAP_LEN    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       A_Req,
  input  logic [2:0] A_Addr,
  input  logic [5:0] A_Data,
  input  logic       B_Req,
  input  logic [2:0] B_Addr,
  input  logic [5:0] B_Data,
  output logic       A_Ack,
  output logic       B_Ack,
  output logic [5:0] Lat_D,
  output logic [7:0] Lat_Cen,
  output logic       Busy
);

  localparam logic [3:0] StrobeCnt = 4'(STROBE_LEN);
  localparam logic [3:0] GapCnt    = 4'(GAP_LEN);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_addr;
  logic       r_gnt_b;
  logic       r_last_b;

  logic w_any;
  logic w_grant_b;

  assign w_any = A_Req | B_Req;
  // r_last_b == 1 means B was served last, so A wins a tie.
  assign w_grant_b = (A_Req & B_Req) ? ~r_last_b : B_Req;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_addr   <= 3'd0;
      r_gnt_b  <= 1'b0;
      r_last_b <= 1'b1;
      A_Ack    <= 1'b0;
      B_Ack    <= 1'b0;
      Lat_D    <= 6'h00;
      Lat_Cen  <= 8'h00;
      Busy     <= 1'b0;
    end else begin
      A_Ack <= 1'b0;
      B_Ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state  <= StSetup;
            r_cnt    <= 4'd1;
            r_gnt_b  <= w_grant_b;
            r_last_b <= w_grant_b;
            r_addr   <= w_grant_b ? B_Addr : A_Addr;
            Lat_D    <= w_grant_b ? B_Data : A_Data;
            Busy     <= 1'b1;
          end
        end
        StSetup: begin
          r_state <= StStrobe;
          r_cnt   <= StrobeCnt;
          Lat_Cen <= 8'(1) << r_addr;
        end
        StStrobe: begin
          if (r_cnt == 4'd1) begin
            r_state <= StHold;
            r_cnt   <= GapCnt;
            Lat_Cen <= 8'h00;
            // A one-cycle hold is also its final cycle, so Ack starts on entry.
            if (GapCnt == 4'd1) begin
              A_Ack <= ~r_gnt_b;
              B_Ack <= r_gnt_b;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StHold: begin
          if (r_cnt == 4'd1) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            Busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd2) begin
              A_Ack <= ~r_gnt_b;
              B_Ack <= r_gnt_b;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 4'd0;
          Lat_Cen <= 8'h00;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_latch_strobe_arbiter.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops one per Ack.
// Instance 0 uses default timing, instance 1 uses STROBE_LEN=1 / GAP_LEN=15.
`timescale 1ns/1ps
module tb_ttl_latch_strobe_arbiter;

  typedef struct packed {
    logic       b;
    logic [7:0] cen;
    logic [5:0] data;
    logic [4:0] slen;
    logic [4:0] dly;
    logic [4:0] period;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0, c_req = 1'b0;
  logic [2:0] a_addr = 3'd0, b_addr = 3'd0, c_addr = 3'd0;
  logic [5:0] a_data = 6'h00, b_data = 6'h00, c_data = 6'h00;
  logic       zero1 = 1'b0;
  logic [2:0] zero3 = 3'd0;
  logic [5:0] zero6 = 6'h00;

  logic       a_ack0, b_ack0, busy0, a_ack1, b_ack1, busy1;
  logic [5:0] lat_d0, lat_d1;
  logic [7:0] cen0, cen1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t q0[$];
  exp_t q1[$];

  int   m_rise[2], m_prev_rise[2], m_cstart[2], m_clen[2];
  logic m_busy[2], m_ack[2];
  logic [7:0] m_cen[2];
  logic [5:0] m_cdat[2];

  ttl_latch_strobe_arbiter u_dut0 (
    .Clk(clk), .Reset(rst),
    .A_Req(a_req), .A_Addr(a_addr), .A_Data(a_data),
    .B_Req(b_req), .B_Addr(b_addr), .B_Data(b_data),
    .A_Ack(a_ack0), .B_Ack(b_ack0), .Lat_D(lat_d0), .Lat_Cen(cen0), .Busy(busy0)
  );

  ttl_latch_strobe_arbiter #(.STROBE_LEN(1), .GAP_LEN(15)) u_dut1 (
    .Clk(clk), .Reset(rst),
    .A_Req(c_req), .A_Addr(c_addr), .A_Data(c_data),
    .B_Req(zero1), .B_Addr(zero3), .B_Data(zero6),
    .A_Ack(a_ack1), .B_Ack(b_ack1), .Lat_D(lat_d1), .Lat_Cen(cen1), .Busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic aa, input logic ab, input logic [7:0] cen,
                     input logic [5:0] ld, input logic bs);
    exp_t e;
    int   have;
    if (bs && !m_busy[d]) begin
      m_prev_rise[d] = m_rise[d];
      m_rise[d]      = cyc;
    end
    m_busy[d] = bs;
    if (cen != 8'h00) begin
      chk("cen_onehot", int'($onehot(cen)), 1);
      if (m_clen[d] == 0) begin
        m_cen[d]    = cen;
        m_cdat[d]   = ld;
        m_cstart[d] = cyc;
      end
      m_clen[d]++;
    end
    if (aa | ab) begin
      chk("ack_exclusive", int'(aa & ab), 0);
      chk("ack_width", int'(m_ack[d]), 0);
      have = (d == 0) ? q0.size() : q1.size();
      chk("ack_expected", int'(have > 0), 1);
      if (have > 0) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("ack_who", int'(ab), int'(e.b));
        chk("cen_value", int'(m_cen[d]), int'(e.cen));
        chk("cen_len", m_clen[d], int'(e.slen));
        chk("cen_data", int'(m_cdat[d]), int'(e.data));
        chk("lat_d_at_ack", int'(ld), int'(e.data));
        chk("setup_len", m_cstart[d] - m_rise[d], 1);
        chk("ack_delay", cyc - m_rise[d], int'(e.dly));
        if (e.period != 0) chk("period", m_rise[d] - m_prev_rise[d], int'(e.period));
      end
      m_clen[d] = 0;
    end
    m_ack[d] = aa | ab;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 1'b0;
        m_ack[d]  = 1'b0;
        m_clen[d] = 0;
      end
    end else begin
      mon(0, a_ack0, b_ack0, cen0, lat_d0, busy0);
      mon(1, a_ack1, b_ack1, cen1, lat_d1, busy1);
    end
  end

  // Drop each request after its requester has been acked na / nb times.
  task automatic run(input int na, input int nb, input int budget);
    int ca = 0;
    int cb = 0;
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (a_ack0) begin ca++; if (ca == na) a_req = 1'b0; end
      if (b_ack0) begin cb++; if (cb == nb) b_req = 1'b0; end
      done = (ca >= na) && (cb >= nb);
    end
    chk("run_done", int'(done), 1);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic exp_t mk(input logic b, input logic [7:0] cen, input logic [5:0] data,
                              input int slen, input int dly, input int period);
    exp_t e;
    e.b = b; e.cen = cen; e.data = data;
    e.slen = 5'(slen); e.dly = 5'(dly); e.period = 5'(period);
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_cen", int'(cen0), 0);
    chk("rst_lat_d", int'(lat_d0), 0);
    chk("rst_acks", int'({a_ack0, b_ack0}), 0);
    rst = 1'b0;

    // A alone: Cen 0x20 for two cycles, Ack four cycles after Busy rises.
    a_addr = 3'd5; a_data = 6'h2A;
    q0.push_back(mk(1'b0, 8'h20, 6'h2A, 2, 4, 0));
    a_req = 1'b1;
    run(1, 0, 40);
    repeat (4) @(negedge clk);
    chk("idle_busy", int'(busy0), 0);
    chk("idle_keeps_lat_d", int'(lat_d0), 'h2A);

    // Simultaneous rise after reset: A first, B granted in the next IDLE cycle.
    pulse_reset();
    a_addr = 3'd0; a_data = 6'h01; b_addr = 3'd7; b_data = 6'h3E;
    q0.push_back(mk(1'b0, 8'h01, 6'h01, 2, 4, 0));
    q0.push_back(mk(1'b1, 8'h80, 6'h3E, 2, 4, 6));
    a_req = 1'b1; b_req = 1'b1;
    run(1, 1, 60);

    // Both held for four writes: strict alternation starting with A.
    repeat (2) @(negedge clk);
    a_addr = 3'd2; a_data = 6'h0A; b_addr = 3'd3; b_data = 6'h0B;
    q0.push_back(mk(1'b0, 8'h04, 6'h0A, 2, 4, 0));
    q0.push_back(mk(1'b1, 8'h08, 6'h0B, 2, 4, 6));
    q0.push_back(mk(1'b0, 8'h04, 6'h0A, 2, 4, 6));
    q0.push_back(mk(1'b1, 8'h08, 6'h0B, 2, 4, 6));
    a_req = 1'b1; b_req = 1'b1;
    run(2, 2, 80);

    // Inputs change mid-write and B pulses while busy: neither may disturb the write.
    repeat (2) @(negedge clk);
    a_addr = 3'd4; a_data = 6'h15;
    q0.push_back(mk(1'b0, 8'h10, 6'h15, 2, 4, 0));
    a_req = 1'b1;
    fork
      run(1, 0, 40);
      begin
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(negedge clk);
          if (cen0 != 8'h00) begin
            seen = 1;
            a_data = 6'h3F; a_addr = 3'd1; b_req = 1'b1;
            @(negedge clk) b_req = 1'b0;
          end
        end
        chk("strobe_seen", int'(seen), 1);
      end
    join
    repeat (6) @(negedge clk);
    chk("pulse_ignored_busy", int'(busy0), 0);
    chk("drain_q0", q0.size(), 0);

    // Reset in the first STROBE cycle: Cen drops at once, then a fresh grant after release.
    a_addr = 3'd6; a_data = 6'h21;
    a_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (cen0 != 8'h00);
    end
    chk("strobe_before_reset", int'(seen), 1);
    #1 rst = 1'b1;
    #1;
    chk("reset_cen_async", int'(cen0), 0);
    chk("reset_busy_async", int'(busy0), 0);
    repeat (2) @(negedge clk);
    chk("reset_no_grant", int'(busy0), 0);
    rst = 1'b0;
    q0.push_back(mk(1'b0, 8'h40, 6'h21, 2, 4, 0));
    @(posedge clk) #1;
    chk("grant_after_release", int'(busy0), 1);
    chk("grant_after_release_d", int'(lat_d0), 'h21);
    run(1, 0, 40);

    // Long-gap instance: 1-cycle strobe, Ack at cycle 17, back-to-back period 18.
    pulse_reset();
    c_addr = 3'd3; c_data = 6'h0C;
    q1.push_back(mk(1'b0, 8'h08, 6'h0C, 1, 16, 0));
    q1.push_back(mk(1'b0, 8'h08, 6'h0C, 1, 16, 18));
    c_req = 1'b1;
    begin
      int n = 0;
      for (int i = 0; i < 100 && n < 2; i++) begin
        @(negedge clk);
        if (a_ack1) begin
          n++;
          if (n == 2) c_req = 1'b0;
        end
      end
      chk("long_acks", n, 2);
      c_req = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("drain_q0_final", q0.size(), 0);
    chk("drain_q1_final", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
